// File: rtl/memory_pkg.sv
// Shared memory-port types and widths for the core wrapper and its arbiter.
package memory_pkg;

  localparam int unsigned MEM_ADDR_WIDTH    = 16;
  localparam int unsigned MEM_DATA_WIDTH    = 32;
  localparam int unsigned MEM_BE_WIDTH      = MEM_DATA_WIDTH / 8;
  localparam int unsigned MEM_N_PORTS       = 2;
  localparam int unsigned MEM_PORT_ID_WIDTH = (MEM_N_PORTS > 1) ? $clog2(MEM_N_PORTS) : 1;

  typedef logic [MEM_PORT_ID_WIDTH-1:0] port_id_t;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
    logic [MEM_BE_WIDTH-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO of requester ids for in-flight reads; push and pop may share a cycle.
module tag_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  // A pop in the same cycle frees the slot a push at full would need.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging N requesters onto one memory port; read data
// returns in order to the issuing requester via a tag FIFO.
module mem_port_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_W  = MEM_DATA_WIDTH,
  parameter int unsigned MAX_OUT = 4,
  localparam int unsigned BE_W   = DATA_W / 8,
  localparam int unsigned PID_W  = $clog2(N_PORTS),
  localparam int unsigned CNT_W  = $clog2(MAX_OUT) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  output logic [N_PORTS-1:0]        req_ready,
  input  logic [N_PORTS-1:0]        req_we,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*DATA_W-1:0] req_wdata,
  input  logic [N_PORTS*BE_W-1:0]   req_be,
  output logic [N_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [BE_W-1:0]           mem_be,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      err_orphan
);

  logic [PID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PID_W-1:0]   lock_id_q, lock_id_d;
  logic               lock_q, lock_d;
  logic               err_orphan_q, err_orphan_d;
  logic [N_PORTS-1:0] eligible;
  logic [PID_W-1:0]   winner;
  logic               accept, push, pop;
  logic               fifo_full, fifo_empty;
  logic [PID_W-1:0]   fifo_head;
  logic [CNT_W-1:0]   fifo_count;

  // First eligible requester at or after ptr, modulo N_PORTS.
  function automatic logic [PID_W-1:0] rr_pick(input logic [N_PORTS-1:0] elig,
                                               input logic [PID_W-1:0]   ptr);
    logic [PID_W-1:0] pick;
    int unsigned      idx;
    pick = ptr;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_PORTS;
      if (elig[PID_W'(idx)]) pick = PID_W'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      eligible[i] = req_valid[i] & (req_we[i] | ~fifo_full);
    end
    // A stalled winner stays granted so a late arrival cannot steal its slot.
    if (lock_q && eligible[lock_id_q]) winner = lock_id_q;
    else                               winner = rr_pick(eligible, rr_ptr_q);

    mem_valid = |eligible;
    accept    = mem_valid & mem_ready;
    mem_we    = mem_valid ? req_we[winner] : 1'b0;
    mem_addr  = mem_valid ? req_addr[int'(winner)*ADDR_W +: ADDR_W] : '0;
    mem_wdata = mem_valid ? req_wdata[int'(winner)*DATA_W +: DATA_W] : '0;
    mem_be    = mem_valid ? req_be[int'(winner)*BE_W +: BE_W] : '0;
    push      = accept & ~req_we[winner];
    pop       = mem_rvalid & ~fifo_empty;

    for (int i = 0; i < N_PORTS; i++) begin
      req_ready[i] = accept && (winner == PID_W'(i));
      rsp_valid[i] = pop && (fifo_head == PID_W'(i));
    end
    rsp_rdata = pop ? mem_rdata : '0;

    lock_d       = mem_valid & ~mem_ready;
    lock_id_d    = winner;
    rr_ptr_d     = rr_ptr_q;
    if (accept) rr_ptr_d = (winner == PID_W'(N_PORTS - 1)) ? '0 : winner + 1'b1;
    err_orphan_d = err_orphan_q | (mem_rvalid & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_id_q    <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign err_orphan = err_orphan_q;

  tag_fifo #(
    .Width(PID_W),
    .Depth(MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(winner),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  occupancy_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CNT_W'(MAX_OUT));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two requesters, four outstanding reads.
module tb_mem_port_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic             clk, rst;
  logic [NP-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*BW-1:0] req_be;
  logic [DW-1:0]    rsp_rdata, mem_wdata, mem_rdata;
  logic             mem_valid, mem_ready, mem_we, mem_rvalid, err_orphan;
  logic [AW-1:0]    mem_addr;
  logic [BW-1:0]    mem_be;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .N_PORTS(NP),
    .ADDR_W (AW),
    .DATA_W (DW),
    .MAX_OUT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .err_orphan(err_orphan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [AW-1:0] a);
    req_valid[p]          = v;
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = {16'h5A00, a};
    req_be[p*BW +: BW]    = 4'hF;
  endtask

  logic [NP-1:0] exp_pat [4];

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;

    // Single read from port 0, data back two cycles later.
    tick();
    set_req(0, 1'b1, 1'b0, 16'h0010);
    mem_ready = 1'b1;
    #1;
    chk("t1_mem_valid", mem_valid, 1);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    chk("t1_req_ready", req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 16'h0);
    #1;
    chk("t1_idle", mem_valid, 0);
    chk("t1_ready_once", req_ready, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();
    mem_rvalid = 1'b0;

    // Both ports read continuously; pointer starts at 1 after test 1.
    exp_pat[0] = 2'b10; exp_pat[1] = 2'b01; exp_pat[2] = 2'b10; exp_pat[3] = 2'b01;
    set_req(0, 1'b1, 1'b0, 16'h0100);
    set_req(1, 1'b1, 1'b0, 16'h0200);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_grant", req_ready, exp_pat[k]);
      chk("t2_addr", mem_addr, exp_pat[k][1] ? 16'h0200 : 16'h0100);
      tick();
    end
    #1;
    chk("t2_full_block", mem_valid, 0);
    set_req(0, 1'b0, 1'b0, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hA0 + k;
      #1;
      chk("t2_rsp_route", rsp_valid, exp_pat[k]);
      chk("t2_rsp_data", rsp_rdata, 32'hA0 + k);
      tick();
    end
    mem_rvalid = 1'b0;

    // Port 1 fills the FIFO; port 0 write still passes.
    set_req(1, 1'b1, 1'b0, 16'h0300);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_fill_grant", req_ready, 2'b10);
      tick();
    end
    #1;
    chk("t3_read_blocked", mem_valid, 0);
    chk("t3_no_ready", req_ready, 0);
    set_req(0, 1'b1, 1'b1, 16'h0040);
    #1;
    chk("t3_write_valid", mem_valid, 1);
    chk("t3_write_we", mem_we, 1);
    chk("t3_write_addr", mem_addr, 16'h0040);
    chk("t3_write_wdata", mem_wdata, 32'h5A000040);
    chk("t3_write_grant", req_ready, 2'b01);
    tick();

    // Full, pop and blocked push in one cycle; read goes one cycle later.
    set_req(0, 1'b0, 1'b0, 16'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'hB0;
    #1;
    chk("t4_push_blocked", mem_valid, 0);
    chk("t4_pop_rsp", rsp_valid, 2'b10);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("t4_read_late", req_ready, 2'b10);
    tick();
    #1;
    chk("t4_full_again", mem_valid, 0);
    set_req(1, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hC0 + k;
      #1;
      chk("t4_drain", rsp_valid, 2'b10);
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    chk("t4_no_orphan", err_orphan, 0);

    // Stall: port 1 granted, port 0 joins (pointer is 0) but must not steal.
    mem_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 16'h0060);
    #1;
    chk("t5_stall_valid", mem_valid, 1);
    chk("t5_stall_addr0", mem_addr, 16'h0060);
    chk("t5_stall_ready", req_ready, 0);
    tick();
    set_req(0, 1'b1, 1'b0, 16'h0050);
    #1;
    chk("t5_hold_addr1", mem_addr, 16'h0060);
    chk("t5_hold_ready", req_ready, 0);
    tick();
    #1;
    chk("t5_hold_addr2", mem_addr, 16'h0060);
    mem_ready = 1'b1;
    #1;
    chk("t5_accept", req_ready, 2'b10);
    tick();
    set_req(1, 1'b0, 1'b0, 16'h0);
    #1;
    chk("t5_next_port0", req_ready, 2'b01);
    chk("t5_next_addr", mem_addr, 16'h0050);
    tick();
    set_req(0, 1'b0, 1'b0, 16'h0);

    // Reset with two reads outstanding; late data becomes orphans.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hE0;
    #1;
    chk("t6_orphan_rsp0", rsp_valid, 0);
    tick();
    #1;
    chk("t6_orphan_rsp1", rsp_valid, 0);
    chk("t6_err_set", err_orphan, 1);
    tick();
    mem_rvalid = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0070);
    #1;
    chk("t6_new_grant", req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 16'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk("t6_new_rsp", rsp_valid, 2'b01);
    chk("t6_new_data", rsp_rdata, 32'h12345678);
    chk("t6_err_sticky", err_orphan, 1);
    tick();
    mem_rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
